// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte-lane transfer sequencer.
package spi_pkg;

   localparam int SPI_BYTE_W        = 8;
   localparam int SPI_BITS_PER_XFER = 8;
   localparam int SPI_BIT_CNT_W     = $clog2(SPI_BITS_PER_XFER);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_SHIFT = 3'd3,
      ST_READ  = 3'd4,
      ST_DONE  = 3'd5
   } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles SCLK every CLK_DIV cycles while enabled, idle low.
// rise_o/fall_o are high in the cycle whose closing edge changes SCLK, so
// the sequencer can act on that same edge.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic clr_n_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       wrap;

   assign wrap = en_i && (cnt_q == HALF_LAST);

   // half-period counter; disabled generator sits cleared with SCLK low
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         cnt_d  = cnt_q + 8'd1;
      end
   end

   // counter and SCLK registers
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = wrap && !sclk_q;
   assign fall_o = wrap && sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI byte-lane transfer sequencer: drives the 8-bit sender/receiver
// datapaths, SCLK and CS_N for one byte per START.
// Build option SPI_BURST_EN: back-to-back bytes with CS_N held low and
// SETUP skipped for chained bytes.
//
//   state | meaning
//   IDLE  | waiting for START, CS_N high
//   LOAD  | parallel-load sender (DP_WRITE)
//   SETUP | CS_N low for CS_SETUP cycles before first SCLK edge
//   SHIFT | 8 SCLK periods with TE/RE enabled
//   READ  | strobe receiver, capture byte, check datapath flags
//   DONE  | one-cycle completion pulse
import spi_pkg::*;

module spi_master_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2
) (
   input  logic                  clk_i,
   input  logic                  clr_n_i,
   input  logic                  start_i,
   input  logic [SPI_BYTE_W-1:0] tx_data_i,
   output logic [SPI_BYTE_W-1:0] rx_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [SPI_BYTE_W-1:0] dp_data_o,
   output logic                  dp_write_o,
   output logic                  dp_te_o,
   output logic                  dp_re_o,
   output logic                  dp_read_o,
   output logic                  dp_clr_o,
   output logic                  sclk_o,
   output logic                  cs_n_o,
   input  logic                  dp_s_empty_i,
   input  logic                  dp_r_full_i,
   input  logic [SPI_BYTE_W-1:0] dp_r_data_i
);

   localparam logic [3:0]               SETUP_LAST = 4'(CS_SETUP - 1);
   localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST   = SPI_BIT_CNT_W'(SPI_BITS_PER_XFER - 1);

   spi_state_e               state_q, state_d;
   logic [3:0]               setup_cnt_q, setup_cnt_d;
   logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                     accept;
   logic                     cs_n_d;
   logic                     sclk_en;
   logic                     sclk_fall;
   logic                     sclk_rise_unused;

   logic [SPI_BYTE_W-1:0]    rx_data_q, dp_data_q;
   logic                     busy_q, done_q, err_q;
   logic                     dp_write_q, dp_te_q, dp_re_q, dp_read_q, dp_clr_q, cs_n_q;

`ifdef SPI_BURST_EN
   assign accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`else
   assign accept = start_i && (state_q == ST_IDLE);
`endif

   assign sclk_en = (state_q == ST_SHIFT);

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk_i   (clk_i),
      .clr_n_i (clr_n_i),
      .en_i    (sclk_en),
      .sclk_o  (sclk_o),
      .rise_o  (sclk_rise_unused),
      .fall_o  (sclk_fall)
   );

   // next-state, setup down-counter and bit counter
   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            setup_cnt_d = SETUP_LAST;
`ifdef SPI_BURST_EN
            // CS_N already low in LOAD means this byte is chained from DONE
            state_d = cs_n_q ? ST_SETUP : ST_SHIFT;
`else
            state_d = ST_SETUP;
`endif
         end
         ST_SETUP: begin
            if (setup_cnt_q == 4'd0) state_d = ST_SHIFT;
            else                     setup_cnt_d = setup_cnt_q - 4'd1;
         end
         ST_SHIFT: begin
            if (sclk_fall) begin
               if (bit_cnt_q == BIT_LAST) begin
                  state_d   = ST_READ;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_READ: state_d = ST_DONE;
         ST_DONE: state_d = accept ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // chip select for the state being entered
   always_comb begin
`ifdef SPI_BURST_EN
      cs_n_d = !((state_d inside {ST_SETUP, ST_SHIFT, ST_READ, ST_DONE}) ||
                 ((state_d == ST_LOAD) && (state_q == ST_DONE)));
`else
      cs_n_d = !(state_d inside {ST_SETUP, ST_SHIFT});
`endif
   end

   // state register with Moore outputs decoded from the state being entered
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q     <= ST_IDLE;
         setup_cnt_q <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         dp_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_te_q     <= 1'b0;
         dp_re_q     <= 1'b0;
         dp_read_q   <= 1'b0;
         dp_clr_q    <= 1'b1;
         cs_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         dp_clr_q    <= 1'b0;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         dp_write_q  <= (state_d == ST_LOAD);
         dp_read_q   <= (state_d == ST_READ);
         dp_te_q     <= (state_d inside {ST_SETUP, ST_SHIFT});
         dp_re_q     <= (state_d inside {ST_SETUP, ST_SHIFT});
         cs_n_q      <= cs_n_d;
         if (accept) begin
            dp_data_q <= tx_data_i;
            err_q     <= 1'b0;
         end
         if (state_q == ST_READ) begin
            rx_data_q <= dp_r_data_i;
            if (!dp_s_empty_i || !dp_r_full_i) err_q <= 1'b1;
         end
      end
   end

   assign rx_data_o  = rx_data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign dp_data_o  = dp_data_q;
   assign dp_write_o = dp_write_q;
   assign dp_te_o    = dp_te_q;
   assign dp_re_o    = dp_re_q;
   assign dp_read_o  = dp_read_q;
   assign dp_clr_o   = dp_clr_q;
   assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default-parameter instance A and a
// CLK_DIV=1/CS_SETUP=1 instance B sharing clock, reset and datapath stubs.
module tb_spi_master_ctrl;

   localparam int D_A = 4;
   localparam int S_A = 2;
   localparam int D_B = 1;
   localparam int S_B = 1;

   logic       clk = 1'b0;
   logic       clr_n = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] tx_data = 8'h00, r_data = 8'h00;
   logic       s_empty = 1'b1, r_full = 1'b1;

   logic [7:0] rx_a, dpd_a, rx_b, dpd_b;
   logic busy_a, done_a, err_a, wr_a, te_a, re_a, rd_a, clr_a, sclk_a, csn_a;
   logic busy_b, done_b, err_b, wr_b, te_b, re_b, rd_b, clr_b, sclk_b, csn_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_master_ctrl #(.CLK_DIV(D_A), .CS_SETUP(S_A)) u_dut_a (
      .clk_i(clk), .clr_n_i(clr_n), .start_i(start_a), .tx_data_i(tx_data),
      .rx_data_o(rx_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
      .dp_data_o(dpd_a), .dp_write_o(wr_a), .dp_te_o(te_a), .dp_re_o(re_a),
      .dp_read_o(rd_a), .dp_clr_o(clr_a), .sclk_o(sclk_a), .cs_n_o(csn_a),
      .dp_s_empty_i(s_empty), .dp_r_full_i(r_full), .dp_r_data_i(r_data));

   spi_master_ctrl #(.CLK_DIV(D_B), .CS_SETUP(S_B)) u_dut_b (
      .clk_i(clk), .clr_n_i(clr_n), .start_i(start_b), .tx_data_i(tx_data),
      .rx_data_o(rx_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
      .dp_data_o(dpd_b), .dp_write_o(wr_b), .dp_te_o(te_b), .dp_re_o(re_b),
      .dp_read_o(rd_b), .dp_clr_o(clr_b), .sclk_o(sclk_b), .cs_n_o(csn_b),
      .dp_s_empty_i(s_empty), .dp_r_full_i(r_full), .dp_r_data_i(r_data));

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      bit         se;
      bit         rf;
      bit         exp_err;
   } vec_t;

   vec_t vecs[4];

   // Reference timing from the transfer rules: LOAD 1, SETUP s, SHIFT 16*d
   // (8 full SCLK periods), READ 1, then DONE; cycle 1 is LOAD.
   function automatic int exp_lat(input int d, input int s);
      return 3 + s + 16 * d;
   endfunction

   function automatic int exp_cs_low(input int d, input int s);
`ifdef SPI_BURST_EN
      return s + 16 * d + 2;
`else
      return s + 16 * d;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic xfer(input bit sel, input logic [7:0] tx, input logic [7:0] rxb,
                       input bit se, input bit rf, input bit hold, input int gap,
                       output int done_cyc, output int cs_low, output int rises,
                       output int hi_cnt, output int max_run, output int te_cnt,
                       output bit load_ok);
      bit prev, sc;
      int run;
      repeat (gap) @(negedge clk);
      tx_data = tx; r_data = rxb; s_empty = se; r_full = rf;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      tx_data = ~tx;
      done_cyc = -1; cs_low = 0; rises = 0; hi_cnt = 0; max_run = 0; te_cnt = 0;
      load_ok = 1'b0; prev = 1'b0; run = 0;
      for (int n = 1; n <= 300; n++) begin
         if (n > 1) begin @(posedge clk); #1; end
         sc = sel ? sclk_b : sclk_a;
         if (n == 1)
            load_ok = sel ? (wr_b && dpd_b == tx && busy_b && !err_b && csn_b)
                          : (wr_a && dpd_a == tx && busy_a && !err_a && csn_a);
         if (!(sel ? csn_b : csn_a)) cs_low++;
         if (sel ? (te_b && re_b) : (te_a && re_a)) te_cnt++;
         if (sc && !prev) rises++;
         if (sc) begin
            hi_cnt++; run++;
            if (run > max_run) max_run = run;
         end else run = 0;
         prev = sc;
         if (sel ? done_b : done_a) begin
            done_cyc = n;
            break;
         end
      end
   endtask

   task automatic run_check(input string tag, input bit sel, input logic [7:0] tx,
                            input logic [7:0] rxb, input bit se, input bit rf,
                            input bit exp_err, input bit hold, input int gap);
      int dc, csl, ri, hc, mr, tc, d, s;
      bit lok;
      d = sel ? D_B : D_A;
      s = sel ? S_B : S_A;
      xfer(sel, tx, rxb, se, rf, hold, gap, dc, csl, ri, hc, mr, tc, lok);
      chk({tag, "_latency"}, dc, exp_lat(d, s));
      chk({tag, "_load"}, int'(lok), 1);
      chk({tag, "_cs_low"}, csl, exp_cs_low(d, s));
      chk({tag, "_rises"}, ri, 8);
      chk({tag, "_sclk_hi"}, hc, 8 * d);
      chk({tag, "_sclk_run"}, mr, d);
      chk({tag, "_te_re"}, tc, s + 16 * d);
      chk({tag, "_rx"}, int'(sel ? rx_b : rx_a), int'(rxb));
      chk({tag, "_err"}, int'(sel ? err_b : err_a), int'(exp_err));
      chk({tag, "_dpdata"}, int'(sel ? dpd_b : dpd_a), int'(tx));
   endtask

   initial begin
      int dones, n, gap, cshi;
      logic [7:0] rtx, rrx;
      bit rse, rrf;

      vecs[0] = '{tx: 8'hA5, rx: 8'hA5, se: 1'b1, rf: 1'b1, exp_err: 1'b0};
      vecs[1] = '{tx: 8'h5A, rx: 8'h3C, se: 1'b1, rf: 1'b0, exp_err: 1'b1};
      vecs[2] = '{tx: 8'h00, rx: 8'hFF, se: 1'b1, rf: 1'b1, exp_err: 1'b0};
      vecs[3] = '{tx: 8'hFF, rx: 8'h00, se: 1'b0, rf: 1'b1, exp_err: 1'b1};

      // reset state
      #1 clr_n = 1'b0;
      #2;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_rx", rx_a, 0);
      chk("rst_csn", csn_a, 1);
      chk("rst_sclk", sclk_a, 0);
      chk("rst_te", te_a, 0);
      chk("rst_dpclr", clr_a, 1);
      @(posedge clk); #2 clr_n = 1'b1;
      @(negedge clk);
      chk("rel_dpclr_hi", clr_a, 1);
      @(posedge clk); #1;
      chk("rel_dpclr_lo", clr_a, 0);

      // table vectors on instance A
      for (int i = 0; i < 4; i++) begin
         run_check($sformatf("vec%0d", i), 1'b0, vecs[i].tx, vecs[i].rx,
                   vecs[i].se, vecs[i].rf, vecs[i].exp_err, 1'b0, 2);
         if (vecs[i].exp_err) begin
            repeat (5) @(posedge clk);
            #1 chk($sformatf("vec%0d_err_sticky", i), err_a, 1);
         end
      end

      // fastest legal timing on instance B
      run_check("fast", 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 2);

      // reset in the middle of SHIFT
      @(negedge clk); @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (19) @(posedge clk);
      #1 chk("mid_busy_before", busy_a, 1);
      #1 clr_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_csn", csn_a, 1);
      chk("mid_rst_sclk", sclk_a, 0);
      chk("mid_rst_te", te_a, 0);
      chk("mid_rst_dpclr", clr_a, 1);
      repeat (2) @(posedge clk);
      #2 clr_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_dpclr_hi", clr_a, 1);
      dones = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (done_a) dones++;
      end
      chk("mid_no_done", dones, 0);
      chk("mid_dpclr_lo", clr_a, 0);
      chk("mid_idle", busy_a, 0);

      // randomized transfers against the reference model
      for (int i = 0; i < 6; i++) begin
         rtx = 8'($urandom);
         rrx = 8'($urandom);
         rse = ($urandom_range(0, 3) != 0);
         rrf = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(2, 5);
         run_check($sformatf("rnd%0d", i), 1'b0, rtx, rrx, rse, rrf, !(rse && rrf), 1'b0, gap);
      end

`ifdef SPI_BURST_EN
      // chained bytes with START held across DONE
      run_check("burst1", 1'b0, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 2);
      chk("burst_done_csn", csn_a, 0);
      @(negedge clk);
      tx_data = 8'h80; r_data = 8'h80;
      @(posedge clk); #1;
      chk("burst_load", int'(wr_a && dpd_a == 8'h80 && csn_a == 1'b0), 1);
      start_a = 1'b0;
      n = -1; cshi = 0;
      for (int k = 1; k <= 300; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (csn_a) cshi++;
         if (done_a) begin n = k; break; end
      end
      chk("burst_gap", n, 16 * D_A + 3);
      chk("burst_cs_high", cshi, 0);
      chk("burst_rx", rx_a, 8'h80);
`else
      // START held through a whole transfer
      run_check("hold", 1'b0, 8'hC3, 8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 2);
      chk("hold_done_csn", csn_a, 1);
      @(posedge clk); #1;
      chk("hold_idle_busy", busy_a, 0);
      chk("hold_idle_csn", csn_a, 1);
      @(posedge clk); #1;
      chk("hold_second_accept", int'(wr_a && busy_a), 1);
      chk("hold_second_data", dpd_a, 8'h3C);
      start_a = 1'b0;
      n = -1;
      for (int k = 2; k <= 300; k++) begin
         @(posedge clk); #1;
         if (done_a) begin n = k; break; end
      end
      chk("hold_second_latency", n, exp_lat(D_A, S_A));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
